mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
- Consumes the 32-bit operands produced by the operand-select muxes in the execute stage.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles.
- Holds HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.

---
 rtl/mult_div_if.sv | 31 +++
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_div_if : operand/result bundle between execute stage and    |
// |               the multiply/divide unit.           Rev 1.0        |
// +------------------------------------------------------------------+
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_div_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO regs.   |
// |                 Rev 1.0                                          |
// +------------------------------------------------------------------+
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mult_div_if.slave bus
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]      r_count;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Operand conditioning at launch: only signed ops fold negatives.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag = w_b_neg ? -bus.b : bus.b;

    // Multiply step: add the current multiplier bit's partial product
    // into the upper half, then shift the whole accumulator right.
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_mul_sum;

    assign w_addend  = r_b_mag[r_count] ? r_a_mag : '0;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Divide step: restoring shift-subtract, dividend bits MSB first.
    logic [CW-1:0]    w_div_idx;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH+1:0] w_sub;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_nxt;

    assign w_div_idx = c_LAST - r_count;
    assign w_trial   = {r_rem, r_a_mag[w_div_idx]};
    assign w_sub     = w_trial - {2'b00, r_b_mag};
    assign w_fits    = ~w_sub[WIDTH+1];
    assign w_rem_nxt = w_fits ? w_sub[WIDTH:0] : w_trial[WIDTH:0];

    // Sign correction; a zero divisor leaves the all-ones quotient raw,
    // while the remainder negation naturally restores the original a.
    logic               w_neg_res;
    logic               w_div_by_zero;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_neg_res     = r_sign_a ^ r_sign_b;
    assign w_div_by_zero = (r_b_mag == '0);
    assign w_prod_fix    = w_neg_res ? -r_acc : r_acc;
    assign w_quo_fix     = (w_neg_res && !w_div_by_zero) ? -r_quo : r_quo;
    assign w_rem_fix     = r_sign_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == c_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_a_mag  <= w_a_mag;
                        r_b_mag  <= w_b_mag;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_rem    <= '0;
                        r_quo    <= '0;
                    end
                end
                S_RUN: begin
                    r_count <= (r_count == c_LAST) ? '0 : r_count + CW'(1);
                    if (r_op[1]) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // HI/LO only change on an idle MT write or the writeback edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                if (r_op[1]) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end else if (r_state == S_IDLE) begin
                if (bus.we_hi) r_hi <= bus.wdata;
                if (bus.we_lo) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mult_div_unit : directed vectors plus per-cycle reference     |
// |                    model compare for mult_div_unit.  Rev 1.0     |
// +------------------------------------------------------------------+
module tb_mult_div_unit;

    localparam int c_LAT = 33;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int done_cnt = 0;
    int busy_cnt = 0;

    // Transaction-level reference: arithmetic result plus fixed latency.
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_res  = '0;
    int          m_cnt  = 0;
    bit          m_done = 1'b0;

    function automatic logic [63:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.we_hi) m_hi <= bus.wdata;
                if (bus.we_lo) m_lo <= bus.wdata;
                if (bus.start) begin
                    m_res <= ref_result(bus.op, bus.a, bus.b);
                    m_cnt <= c_LAT;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        launch(op, a, b);
        repeat (c_LAT) tick();
        check({name, ".done"}, 64'(bus.done), 64'd1);
        check({name, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, ".lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        int d0, b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wdata = '0;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    check("cyc.busy", 64'(bus.busy), 64'(m_cnt != 0));
                    check("cyc.done", 64'(bus.done), 64'(m_done));
                    check("cyc.hi", 64'(bus.hi), 64'(m_hi));
                    check("cyc.lo", 64'(bus.lo), 64'(m_lo));
                end
                if (bus.done) done_cnt++;
                if (bus.busy) busy_cnt++;
            end
        join_none

        repeat (3) tick();
        check("rst.hi", 64'(bus.hi), 64'd0);
        check("rst.lo", 64'(bus.lo), 64'd0);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        d0 = done_cnt;
        b0 = busy_cnt;
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        check("multu_max.busy_cycles", 64'(busy_cnt - b0), 64'd33);
        check("multu_max.done_pulses", 64'(done_cnt - d0), 64'd1);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Idle MT writes
        bus.we_hi = 1'b1;
        bus.wdata = 32'h1234_5678;
        tick();
        bus.we_hi = 1'b0;
        check("mthi.hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi.lo", 64'(bus.lo), 64'h8000_0000);
        bus.we_hi = 1'b1;
        bus.we_lo = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        tick();
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        check("mtboth.hi", 64'(bus.hi), 64'hCAFE_F00D);
        check("mtboth.lo", 64'(bus.lo), 64'hCAFE_F00D);

        // Start and MT writes presented while busy must be ignored
        d0 = done_cnt;
        launch(2'b11, 32'd100, 32'd7);
        repeat (5) tick();
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        bus.we_hi = 1'b1;
        bus.we_lo = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        bus.start = 1'b0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        check("busy_in.mid_hi", 64'(bus.hi), 64'hCAFE_F00D);
        repeat (25) tick();
        check("busy_in.hi", 64'(bus.hi), 64'd2);
        check("busy_in.lo", 64'(bus.lo), 64'd14);
        tick();
        check("busy_in.done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_in.idle", 64'(bus.busy), 64'd0);

        // Start together with MTHI: MT value visible until writeback
        bus.we_hi = 1'b1;
        bus.wdata = 32'hAAAA_5555;
        launch(2'b01, 32'd3, 32'd4);
        bus.we_hi = 1'b0;
        check("st_mt.hi_early", 64'(bus.hi), 64'hAAAA_5555);
        repeat (c_LAT) tick();
        check("st_mt.hi", 64'(bus.hi), 64'd0);
        check("st_mt.lo", 64'(bus.lo), 64'd12);

        // Back-to-back: second start in the done cycle
        run_op("b2b_first", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        launch(2'b11, 32'd100, 32'd7);
        check("b2b.busy", 64'(bus.busy), 64'd1);
        check("b2b.lo_held", 64'(bus.lo), 64'd42);
        repeat (c_LAT) tick();
        check("b2b.done", 64'(bus.done), 64'd1);
        check("b2b.hi", 64'(bus.hi), 64'd2);
        check("b2b.lo", 64'(bus.lo), 64'd14);

        // Reset in the middle of a MULT
        launch(2'b00, 32'h0001_2345, 32'h0000_6789);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midrst.hi", 64'(bus.hi), 64'd0);
        check("midrst.lo", 64'(bus.lo), 64'd0);
        check("midrst.busy", 64'(bus.busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) tick();
        check("midrst.no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst.hi_after", 64'(bus.hi), 64'd0);
        check("midrst.lo_after", 64'(bus.lo), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
